// File: rtl/wrk_cell_dispatch_if.sv
// Cell ingress and worker fan-out bus for wrk_cell_dispatch.
// The dispatcher uses the slave side; the upstream/worker model uses the master side.
interface wrk_cell_dispatch_if #(
    parameter int WRK_NUM = 8,
    parameter int DWID    = 256
) ();
    logic               in_vld;
    logic [DWID-1:0]    in_data;
    logic               in_rdy;
    logic [WRK_NUM-1:0] wrk_vld;
    logic               wrk_sof;
    logic [DWID-1:0]    wrk_data;
    logic [WRK_NUM-1:0] wrk_done;

    modport slave (
        input  in_vld, in_data, wrk_done,
        output in_rdy, wrk_vld, wrk_sof, wrk_data
    );

    modport master (
        output in_vld, in_data, wrk_done,
        input  in_rdy, wrk_vld, wrk_sof, wrk_data
    );
endinterface

// File: rtl/wrk_cell_dispatch.sv
// Round-robin cell dispatcher: routes fixed-length cells to idle worker engines,
// tracks completions and emits spaced exit pulses.
module wrk_cell_dispatch #(
    parameter int WRK_NUM    = 8,
    parameter int DWID       = 256,
    parameter int CELL_LEN   = 4,
    parameter int RDY_MARGIN = 2,
    parameter int DBG_WID    = 32
) (
    input  logic                clk,
    input  logic                rst,
    wrk_cell_dispatch_if.slave  bus,
    output logic                flag_wrk_exit,
    output logic [31:0]         cnt_drop,
    output logic [31:0]         cnt_done_err,
    output logic [DBG_WID-1:0]  dbg_sig
);
    localparam int PTRW     = $clog2(WRK_NUM);
    localparam int BCW      = $clog2(CELL_LEN);
    localparam int PW       = $clog2(2 * WRK_NUM + 1);
    localparam int CW       = $clog2(WRK_NUM + 1);
    localparam int PEND_MAX = (1 << PW) - 1;
    localparam int DBG_RAW  = WRK_NUM + PTRW + PW + BCW;

    logic [WRK_NUM-1:0] busy_q, busy_d, done_ok, done_bad, grant_oh, vld_q, vld_d;
    logic [PTRW-1:0]    rr_ptr_q, rr_ptr_d, grant_idx, cand, cell_idx_q, cell_idx_d, route_idx;
    logic [BCW-1:0]     beat_q, beat_d;
    logic [PW-1:0]      pend_q, pend_d;
    logic [CW-1:0]      n_done, n_err, n_idle;
    logic [DWID-1:0]    data_q, data_d;
    logic [31:0]        drop_q, drop_d, derr_q, derr_d;
    logic [32:0]        derr_sum;
    logic               found, cell_start, route_ok, cell_ok_q, cell_ok_d;
    logic               sof_q, sof_d, exit_q, exit_d, in_rdy_q, in_rdy_d;
    int                 pend_sum;

    assign done_ok    = bus.wrk_done & busy_q;
    assign done_bad   = bus.wrk_done & ~busy_q;
    assign cell_start = bus.in_vld && (beat_q == '0);

    // First idle worker at or above rr_ptr, wrapping modulo WRK_NUM.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < WRK_NUM; k++) begin
            cand = PTRW'((int'(rr_ptr_q) + k) % WRK_NUM);
            if (!found && !busy_q[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_oh   = '0;
        rr_ptr_d   = rr_ptr_q;
        cell_ok_d  = cell_ok_q;
        cell_idx_d = cell_idx_q;
        drop_d     = drop_q;
        if (cell_start) begin
            cell_ok_d  = found;
            cell_idx_d = grant_idx;
            if (found) begin
                grant_oh = WRK_NUM'(1) << grant_idx;
                rr_ptr_d = (grant_idx == PTRW'(WRK_NUM - 1)) ? '0 : grant_idx + 1'b1;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 32'd1;
            end
        end
        busy_d    = (busy_q & ~done_ok) | grant_oh;
        route_ok  = cell_start ? found : cell_ok_q;
        route_idx = cell_start ? grant_idx : cell_idx_q;
        vld_d     = (bus.in_vld && route_ok) ? (WRK_NUM'(1) << route_idx) : '0;
        data_d    = (bus.in_vld && route_ok) ? bus.in_data : data_q;
        sof_d     = cell_start && found;
        beat_d    = beat_q;
        if (bus.in_vld) begin
            beat_d = (beat_q == BCW'(CELL_LEN - 1)) ? '0 : beat_q + 1'b1;
        end
    end

    always_comb begin
        n_done = '0;
        n_err  = '0;
        n_idle = '0;
        for (int k = 0; k < WRK_NUM; k++) begin
            n_done = n_done + CW'(done_ok[k]);
            n_err  = n_err + CW'(done_bad[k]);
            n_idle = n_idle + CW'(!busy_d[k]);
        end
        in_rdy_d = int'(n_idle) >= RDY_MARGIN;
        // Pending completions clamp rather than wrap.
        pend_sum = int'(pend_q) + int'(n_done) - int'(exit_q);
        if (pend_sum > PEND_MAX) pend_sum = PEND_MAX;
        if (pend_sum < 0) pend_sum = 0;
        pend_d   = PW'(pend_sum);
        exit_d   = (pend_q != '0) && !exit_q;
        derr_sum = {1'b0, derr_q} + 33'(n_err);
        derr_d   = derr_sum[32] ? '1 : derr_sum[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            rr_ptr_q   <= '0;
            beat_q     <= '0;
            pend_q     <= '0;
            cell_ok_q  <= 1'b0;
            cell_idx_q <= '0;
            vld_q      <= '0;
            sof_q      <= 1'b0;
            data_q     <= '0;
            exit_q     <= 1'b0;
            in_rdy_q   <= 1'b0;
            drop_q     <= '0;
            derr_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_q     <= beat_d;
            pend_q     <= pend_d;
            cell_ok_q  <= cell_ok_d;
            cell_idx_q <= cell_idx_d;
            vld_q      <= vld_d;
            sof_q      <= sof_d;
            data_q     <= data_d;
            exit_q     <= exit_d;
            in_rdy_q   <= in_rdy_d;
            drop_q     <= drop_d;
            derr_q     <= derr_d;
        end
    end

    assign bus.in_rdy   = in_rdy_q;
    assign bus.wrk_vld  = vld_q;
    assign bus.wrk_sof  = sof_q;
    assign bus.wrk_data = data_q;
    assign flag_wrk_exit = exit_q;
    assign cnt_drop      = drop_q;
    assign cnt_done_err  = derr_q;

    logic [DBG_RAW-1:0] dbg_raw;
    assign dbg_raw = {busy_q, rr_ptr_q, pend_q, beat_q};
    assign dbg_sig = DBG_WID'(dbg_raw);
endmodule

// File: tb/tb_wrk_cell_dispatch.sv
// Scoreboard bench for wrk_cell_dispatch: directed cells, completions and resets,
// with a decoupled monitor checking every worker beat.
module tb_wrk_cell_dispatch;
    localparam int WRK_NUM    = 8;
    localparam int DWID       = 32;
    localparam int CELL_LEN   = 4;
    localparam int RDY_MARGIN = 2;
    localparam int DBG_WID    = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               flag_wrk_exit;
    logic [31:0]        cnt_drop, cnt_done_err;
    logic [DBG_WID-1:0] dbg_sig;

    wrk_cell_dispatch_if #(.WRK_NUM(WRK_NUM), .DWID(DWID)) bus ();

    wrk_cell_dispatch #(
        .WRK_NUM(WRK_NUM), .DWID(DWID), .CELL_LEN(CELL_LEN),
        .RDY_MARGIN(RDY_MARGIN), .DBG_WID(DBG_WID)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .flag_wrk_exit(flag_wrk_exit),
        .cnt_drop(cnt_drop), .cnt_done_err(cnt_done_err), .dbg_sig(dbg_sig)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          worker;
        bit          sof;
        logic [31:0] data;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    pulse_cyc[$];
    int    checks = 0, errors = 0, cyc = 0, exit_cnt = 0, b2b = 0, e0 = 0, span = 0;
    logic  prev_flag = 1'b0;

    always @(posedge clk) cyc++;

    // dbg_sig layout: busy[17:10], rr_ptr[9:7], pend[6:2], beat[1:0]
    function automatic logic [7:0] dbg_busy(); return dbg_sig[17:10]; endfunction
    function automatic logic [2:0] dbg_rr();   return dbg_sig[9:7];   endfunction
    function automatic logic [4:0] dbg_pend(); return dbg_sig[6:2];   endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cell(input int cid, input int worker, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 32'hC000_0000 | 32'(cid * 256 + b);
            if (worker >= 0) exp_q.push_back('{worker, b == 0, bus.in_data, cyc + 1});
            @(posedge clk);
            #1;
        end
        bus.in_vld = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wrk_vld != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got wrk_vld %0h, expected none", bus.wrk_vld);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_vld", 64'(bus.wrk_vld), 64'(1) << mon_e.worker);
                    check("beat_sof", 64'(bus.wrk_sof), 64'(mon_e.sof));
                    check("beat_data", 64'(bus.wrk_data), 64'(mon_e.data));
                    check("beat_cyc", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (flag_wrk_exit) begin
                exit_cnt++;
                pulse_cyc.push_back(cyc);
                if (prev_flag) b2b++;
            end
            prev_flag = flag_wrk_exit;
        end else begin
            prev_flag = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_vld = 1'b0;
        bus.in_data = '0;
        bus.wrk_done = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", 64'(bus.in_rdy), 64'(0));
        check("rst_wrk_vld", 64'(bus.wrk_vld), 64'(0));
        check("rst_sof_data", 64'({bus.wrk_sof, bus.wrk_data}), 64'(0));
        check("rst_counters", {cnt_drop, cnt_done_err}, 64'(0));
        check("rst_exit_dbg", 64'({flag_wrk_exit, dbg_sig}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(1);
        check("in_rdy_after_rst", 64'(bus.in_rdy), 64'(1));

        // Eight back-to-back cells fill every worker, ninth is dropped
        for (int c = 0; c < 6; c++) send_cell(c, c, CELL_LEN);
        check("in_rdy_6_busy", 64'(bus.in_rdy), 64'(1));
        send_cell(6, 6, CELL_LEN);
        check("in_rdy_7_busy", 64'(bus.in_rdy), 64'(0));
        send_cell(7, 7, CELL_LEN);
        check("busy_full", 64'(dbg_busy()), 64'(8'hFF));
        check("rr_wrap", 64'(dbg_rr()), 64'(0));
        send_cell(8, -1, CELL_LEN);
        check("cnt_drop_1", 64'(cnt_drop), 64'(1));
        check("rr_after_drop", 64'(dbg_rr()), 64'(0));

        // Single completion frees worker 3, next cell lands there
        e0 = exit_cnt;
        bus.wrk_done = 8'h08;
        cycles(1);
        bus.wrk_done = '0;
        check("busy_clear3", 64'(dbg_busy()), 64'(8'hF7));
        cycles(4);
        check("exit_one", 64'(exit_cnt - e0), 64'(1));
        send_cell(9, 3, CELL_LEN);
        check("busy_regrant3", 64'(dbg_busy()), 64'(8'hFF));
        check("rr_after3", 64'(dbg_rr()), 64'(4));

        // All eight complete at once
        e0 = exit_cnt;
        pulse_cyc.delete();
        bus.wrk_done = 8'hFF;
        cycles(1);
        bus.wrk_done = '0;
        check("pend_8", 64'(dbg_pend()), 64'(8));
        check("busy_all_idle", 64'(dbg_busy()), 64'(0));
        cycles(20);
        check("exit_eight", 64'(exit_cnt - e0), 64'(8));
        span = (pulse_cyc.size() > 0) ? pulse_cyc[pulse_cyc.size() - 1] - pulse_cyc[0] : -1;
        check("exit_span", 64'(span), 64'(14));
        check("pend_drained", 64'(dbg_pend()), 64'(0));

        // Completions on idle workers are errors only
        e0 = exit_cnt;
        bus.wrk_done = 8'h20;
        cycles(1);
        bus.wrk_done = '0;
        cycles(4);
        check("done_err_1", 64'(cnt_done_err), 64'(1));
        check("done_err_no_exit", 64'(exit_cnt - e0), 64'(0));
        check("done_err_busy", 64'(dbg_busy()), 64'(0));
        bus.wrk_done = 8'h21;
        cycles(1);
        bus.wrk_done = '0;
        check("done_err_3", 64'(cnt_done_err), 64'(3));

        // Grant and completion in the same cycle while pend=1
        send_cell(10, 4, CELL_LEN);
        send_cell(11, 5, CELL_LEN);
        e0 = exit_cnt;
        bus.wrk_done = 8'h10;
        cycles(1);
        check("pend_1", 64'(dbg_pend()), 64'(1));
        fork
            send_cell(12, 6, CELL_LEN);
            begin
                bus.wrk_done = 8'h20;
                cycles(1);
                bus.wrk_done = '0;
                check("pend_2", 64'(dbg_pend()), 64'(2));
                check("busy_grant_done", 64'(dbg_busy()), 64'(8'h40));
            end
        join
        cycles(8);
        check("exit_two", 64'(exit_cnt - e0), 64'(2));
        check("pend_zero", 64'(dbg_pend()), 64'(0));
        check("rr_after6", 64'(dbg_rr()), 64'(7));

        // Reset at beat 2 of a cell
        send_cell(13, 7, 2);
        @(negedge clk);
        #1;
        bus.in_vld = 1'b1;
        bus.in_data = 32'hC000_0D02;
        rst = 1'b1;
        #1;
        check("midrst_wrk", 64'({bus.wrk_vld, bus.wrk_sof, bus.in_rdy}), 64'(0));
        check("midrst_data", 64'(bus.wrk_data), 64'(0));
        check("midrst_state", 64'({flag_wrk_exit, dbg_sig}), 64'(0));
        check("midrst_counters", {cnt_drop, cnt_done_err}, 64'(0));
        cycles(2);
        bus.in_vld = 1'b0;
        #1 rst = 1'b0;
        cycles(1);
        check("in_rdy_after_rst2", 64'(bus.in_rdy), 64'(1));
        send_cell(14, 0, CELL_LEN);
        check("busy_after_rst", 64'(dbg_busy()), 64'(8'h01));
        check("rr_after_rst", 64'(dbg_rr()), 64'(1));

        cycles(4);
        check("sb_empty", 64'(exp_q.size()), 64'(0));
        check("exit_gap", 64'(b2b), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
